lvds_tx: RTL and testbench

//   Transmit end of the source-synchronous LVDS link: forwarded clock, LVDS_LEN data pairs, one strobe pair.

---
 rtl/lvds_tx.sv | 136 +++++++++++++
 tb/tb_lvds_tx.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_tx.sv
// Transmit end of the source-synchronous LVDS link: input FIFO, strobe-framed burst
// sequencer and registered pad drivers for the forwarded clock, data and strobe pairs.
module lvds_tx #(
  parameter int LVDS_LEN   = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_CYCLES = 2,
  parameter int MAX_BURST  = 0
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        Enable,
  input  logic [LVDS_LEN-1:0]         DataIN,
  input  logic                        DataValid,
  output logic                        DataReady,
  output logic [$clog2(FIFO_DEPTH):0] Level,
  output logic                        Busy,
  output logic [1:0]                  Clock_diff,
  output logic [LVDS_LEN-1:0]         Data_p,
  output logic [LVDS_LEN-1:0]         Data_n,
  output logic [1:0]                  Strob_diff
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = $clog2(GAP_CYCLES + 1) + 1;
  localparam int BW = $clog2(MAX_BURST + 2) + 1;

  localparam logic [LW-1:0] FULL  = LW'(FIFO_DEPTH);
  localparam logic [GW-1:0] GAP_C = GW'(GAP_CYCLES);
  localparam logic [BW-1:0] MAX_B = BW'(MAX_BURST);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  logic [LVDS_LEN-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [LW-1:0]       count;

  logic [1:0]          state;
  logic [GW-1:0]       gap_cnt;
  logic [BW-1:0]       burst_cnt;
  logic [LVDS_LEN-1:0] data_p0;
  logic                vld_p0;
  logic [LVDS_LEN-1:0] tx_data;
  logic                tx_strob;

  logic wr_en;
  logic rd_en;
  logic have_word;
  logic burst_room;
  logic gap_done;

  function automatic logic [BW-1:0] sat_inc(input logic [BW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign DataReady  = ~Reset & (count != FULL);
  assign Level      = count;
  assign Busy       = (state != IDLE);

  assign wr_en      = DataValid & DataReady;
  assign have_word  = Enable & (count != '0);
  assign burst_room = (MAX_BURST == 0) || (burst_cnt < MAX_B);
  assign gap_done   = (state == GAP) && (gap_cnt == GAP_C);
  // A finished gap may launch the next burst directly so the low time is exactly GAP_CYCLES.
  assign rd_en      = have_word & ((state == IDLE) | ((state == SEND) & burst_room) | gap_done);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (wr_en) mem[wr_ptr] <= DataIN;
  end

  // p0: burst sequencer pops the FIFO head into the launch register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      burst_cnt <= '0;
      data_p0   <= '0;
      vld_p0    <= 1'b0;
    end else if (rd_en) begin
      data_p0   <= mem[rd_ptr];
      vld_p0    <= 1'b1;
      burst_cnt <= (state == SEND) ? sat_inc(burst_cnt) : BW'(1);
      state     <= SEND;
    end else begin
      data_p0 <= '0;
      vld_p0  <= 1'b0;
      case (state)
        SEND: begin
          state   <= GAP;
          gap_cnt <= GW'(1);
        end
        GAP: begin
          if (gap_done) state <= IDLE;
          else          gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // p1: pad registers, launched on the rising edge for falling-edge capture at the far end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      tx_data  <= '0;
      tx_strob <= 1'b0;
    end else begin
      tx_data  <= data_p0;
      tx_strob <= vld_p0;
    end
  end

  assign Clock_diff = {~Clock, Clock};
  assign Data_p     = tx_data;
  assign Data_n     = ~tx_data;
  assign Strob_diff = {~tx_strob, tx_strob};

endmodule

// File: tb/tb_lvds_tx.sv
// Directed bench for lvds_tx: an unlimited-burst instance and a MAX_BURST=4/GAP=3 instance,
// checked against a word scoreboard and burst/gap bookkeeping taken from the pins.
module tb_lvds_tx;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       en_a, dv_a, rdy_a, busy_a;
  logic [7:0] din_a, dp_a, dn_a;
  logic [4:0] lvl_a;
  logic [1:0] ck_a, st_a;

  logic       en_b, dv_b, rdy_b, busy_b;
  logic [7:0] din_b, dp_b, dn_b;
  logic [4:0] lvl_b;
  logic [1:0] ck_b, st_b;

  lvds_tx #(.LVDS_LEN(8), .FIFO_DEPTH(16), .GAP_CYCLES(2), .MAX_BURST(0)) dut_a (
    .Clock(clk), .Reset(rst), .Enable(en_a), .DataIN(din_a), .DataValid(dv_a),
    .DataReady(rdy_a), .Level(lvl_a), .Busy(busy_a), .Clock_diff(ck_a),
    .Data_p(dp_a), .Data_n(dn_a), .Strob_diff(st_a));

  lvds_tx #(.LVDS_LEN(8), .FIFO_DEPTH(16), .GAP_CYCLES(3), .MAX_BURST(4)) dut_b (
    .Clock(clk), .Reset(rst), .Enable(en_b), .DataIN(din_b), .DataValid(dv_b),
    .DataReady(rdy_b), .Level(lvl_b), .Busy(busy_b), .Clock_diff(ck_b),
    .Data_p(dp_b), .Data_n(dn_b), .Strob_diff(st_b));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wcyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model A: every accepted word must appear once, in order, one strobe cycle each.
  logic [7:0] sb_a [$];
  logic [7:0] log_a [$];
  int         bursts_a [$];
  int         run_a = 0, low_a = 0, first_cyc_a = -1;
  bit         seen_a = 0;
  logic [7:0] exp_a;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    if (rst) sb_a.delete();
    else if (dv_a && rdy_a) sb_a.push_back(din_a);
  end

  always @(posedge clk) begin
    #1;
    chk("clk_diff_hi_a", ck_a, 2'b01);
    chk("clk_diff_hi_b", ck_b, 2'b01);
  end

  always @(negedge clk) begin
    chk("clk_diff_lo_a", ck_a, 2'b10);
    if (rst) begin
      chk("ready_in_reset", rdy_a, 0);
      run_a = 0; low_a = 0; seen_a = 0;
    end else begin
      chk("ready_rule", rdy_a, lvl_a != 16);
      chk("data_n_leg", dn_a ^ dp_a, 8'hFF);
      chk("strob_n_leg", st_a[1] ^ st_a[0], 1);
      if (st_a[0]) begin
        chk("busy_in_burst", busy_a, 1);
        if (run_a == 0) begin
          if (seen_a) chk("min_gap", low_a >= 2, 1);
          first_cyc_a = cyc;
        end
        checks++;
        if (sb_a.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", dp_a);
        end else begin
          exp_a = sb_a.pop_front();
          if (dp_a !== exp_a) begin
            errors++;
            $display("FAIL word_order: got %0h expected %0h", dp_a, exp_a);
          end
        end
        log_a.push_back(dp_a);
        run_a++; low_a = 0; seen_a = 1;
      end else begin
        chk("idle_data_zero", dp_a, 0);
        if (run_a > 0) bursts_a.push_back(run_a);
        run_a = 0;
        low_a++;
      end
    end
  end

  // Model B: record words, burst lengths and strobe-low runs between bursts.
  logic [7:0] log_b [$];
  int         bursts_b [$];
  int         gaps_b [$];
  int         run_b = 0, low_b = 0;
  bit         seen_b = 0;

  always @(negedge clk) begin
    chk("clk_diff_lo_b", ck_b, 2'b10);
    if (rst) begin
      run_b = 0; low_b = 0; seen_b = 0;
    end else begin
      chk("data_n_leg_b", dn_b ^ dp_b, 8'hFF);
      if (st_b[0]) begin
        if (run_b == 0 && seen_b) gaps_b.push_back(low_b);
        log_b.push_back(dp_b);
        run_b++; low_b = 0; seen_b = 1;
      end else begin
        if (run_b > 0) bursts_b.push_back(run_b);
        run_b = 0;
        low_b++;
      end
    end
  end

  initial begin
    rst = 1'b1;
    en_a = 0; dv_a = 0; din_a = '0;
    en_b = 0; dv_b = 0; din_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_level", lvl_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_strob", st_a, 2'b10);
    chk("rst_data", dp_a, 0);
    chk("rst_ready", rdy_a, 0);
    chk("rst_busy_b", busy_b, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", rdy_a, 1);
    chk("ready_after_reset_b", rdy_b, 1);

    // 1: three back-to-back words, two-edge latency, run-dry gap
    en_a = 1;
    @(posedge clk); #1 dv_a = 1; din_a = 8'h11;
    @(posedge clk); #1 wcyc = cyc; din_a = 8'h22;
    @(posedge clk); #1 din_a = 8'h33;
    @(posedge clk); #1 dv_a = 0;
    repeat (8) @(posedge clk); #1;
    chk("t1_latency", first_cyc_a - wcyc, 2);
    chk("t1_burst_len", bursts_a[$], 3);
    chk("t1_word0", log_a[0], 8'h11);
    chk("t1_word1", log_a[1], 8'h22);
    chk("t1_word2", log_a[2], 8'h33);
    chk("t1_level", lvl_a, 0);
    chk("t1_busy", busy_a, 0);

    // 2: fill to full with Enable low, 17th write refused
    en_a = 0; log_a.delete(); bursts_a.delete();
    dv_a = 1;
    for (int i = 0; i < 17; i++) begin
      din_a = 8'(8'h40 + i);
      @(posedge clk); #1;
    end
    dv_a = 0;
    chk("t2_level_full", lvl_a, 16);
    chk("t2_ready_full", rdy_a, 0);
    en_a = 1;
    repeat (25) @(posedge clk); #1;
    chk("t2_count", log_a.size(), 16);
    chk("t2_burst_len", bursts_a[$], 16);
    chk("t2_first", log_a[0], 8'h40);
    chk("t2_last", log_a[15], 8'h4F);
    chk("t2_level_empty", lvl_a, 0);

    // 4: Enable dropped after the third pop of an 8-word queue
    en_a = 0; log_a.delete(); bursts_a.delete();
    dv_a = 1;
    for (int i = 0; i < 8; i++) begin
      din_a = 8'(8'h80 + i);
      @(posedge clk); #1;
    end
    dv_a = 0;
    chk("t4_level_8", lvl_a, 8);
    en_a = 1;
    repeat (3) @(posedge clk); #1 en_a = 0;
    repeat (6) @(posedge clk); #1;
    chk("t4_burst1", bursts_a[$], 3);
    chk("t4_level_5", lvl_a, 5);
    chk("t4_word2", log_a[2], 8'h82);
    en_a = 1;
    repeat (12) @(posedge clk); #1;
    chk("t4_burst2", bursts_a[$], 5);
    chk("t4_count", log_a.size(), 8);
    chk("t4_word7", log_a[7], 8'h87);
    chk("t4_level_0", lvl_a, 0);

    // 5: reset mid-burst with 6 words queued
    en_a = 0; log_a.delete(); bursts_a.delete();
    dv_a = 1;
    for (int i = 0; i < 6; i++) begin
      din_a = 8'(8'hA0 + i);
      @(posedge clk); #1;
    end
    dv_a = 0;
    en_a = 1;
    repeat (3) @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_strob_low", st_a, 2'b10);
    chk("t5_level", lvl_a, 0);
    chk("t5_busy", busy_a, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk); #1;
    chk("t5_words_before_reset", log_a.size(), 1);
    chk("t5_word0", log_a[0], 8'hA0);
    chk("t5_level_after", lvl_a, 0);
    chk("t5_busy_after", busy_a, 0);

    // 6: steady write+read around half full
    en_a = 0; log_a.delete(); bursts_a.delete();
    dv_a = 1;
    for (int i = 0; i < 8; i++) begin
      din_a = 8'(8'h01 + i);
      @(posedge clk); #1;
    end
    en_a = 1;
    for (int i = 0; i < 40; i++) begin
      din_a = 8'(8'hC0 + i);
      @(posedge clk); #1;
      chk("t6_level_const", lvl_a, 8);
    end
    dv_a = 0;
    repeat (15) @(posedge clk); #1;
    chk("t6_burst_len", bursts_a[$], 48);
    chk("t6_count", log_a.size(), 48);
    chk("t6_word8", log_a[8], 8'hC0);
    chk("t6_level_0", lvl_a, 0);

    // 3: MAX_BURST=4, GAP_CYCLES=3, ten words queued
    dv_b = 1;
    for (int i = 0; i < 10; i++) begin
      din_b = 8'(i + 1);
      @(posedge clk); #1;
    end
    dv_b = 0;
    chk("t3_level_10", lvl_b, 10);
    en_b = 1;
    repeat (30) @(posedge clk); #1;
    chk("t3_nbursts", bursts_b.size(), 3);
    chk("t3_burst0", bursts_b[0], 4);
    chk("t3_burst1", bursts_b[1], 4);
    chk("t3_burst2", bursts_b[2], 2);
    chk("t3_ngaps", gaps_b.size(), 2);
    chk("t3_gap0", gaps_b[0], 3);
    chk("t3_gap1", gaps_b[1], 3);
    chk("t3_count", log_b.size(), 10);
    for (int i = 0; i < 10; i++) chk("t3_word", log_b[i], i + 1);
    chk("t3_level_0", lvl_b, 0);
    chk("t3_busy", busy_b, 0);

    chk("final_sb_empty", sb_a.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
